dm_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the word-wide data memory (`dm`). It shares the single memory port between requester 0 (CPU load/store unit) and requester 1 (debug/DMA loader) using round-robin arbitration. It turns byte-enabled sub-word stores into read-modify-write sequences, because the memory only writes whole words. It sits between the datapath's memory stage and `dm`, and drives `dm`'s MemRead/MemWrite/MemAddr/WD directly.

---
 rtl/dm_arb_pkg.sv | 26 ++
 rtl/dm_arbiter_byte_merge.sv | 22 ++
 rtl/dm_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_dm_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// Shared types and constants for the dm_arbiter slice.
// Optional feature macro: DM_ARB_SUBWORD_EN (byte-enabled read-modify-write stores).
package dm_arb_pkg;

    // Sequencer states. WRBACK is only entered when sub-word stores are enabled.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WRBACK = 2'd2
    } arbState_t;

    // Requester index: port 0 is the CPU load/store unit, port 1 the debug/DMA loader.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } portIdx_t;

    // Byte-enable pattern that covers the whole word.
    localparam logic [3:0] FULL_BE = 4'b1111;

    // The round-robin pointer always hands priority to the port that did not just win.
    function automatic portIdx_t otherPort(input portIdx_t p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/dm_arbiter_byte_merge.sv
// Combinational lane merge: enabled byte lanes come from newWord, the rest from oldWord.
// Used to build the write-back word of a read-modify-write sub-word store.
module dm_byte_merge (
    input  logic [31:0] oldWord,
    input  logic [31:0] newWord,
    input  logic [3:0]  be,
    output logic [31:0] mergedWord
);

    // Select each byte lane from the new or the old word according to its enable.
    always_comb begin
        // NOTE: assigning a default before the conditional updates keeps every bit
        // driven on every path, so no latch is inferred.
        mergedWord = oldWord;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                mergedWord[8*i +: 8] = newWord[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of the data memory.
// Shares the single memory port between the CPU (port 0) and the debug/DMA loader
// (port 1), and turns byte-enabled stores into read-modify-write sequences.
// Optional feature macro: DM_ARB_SUBWORD_EN. When undefined, byte enables are
// ignored, every store is a single full-word write and WRBACK is never used.
module dm_arbiter
    import dm_arb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [31:0]       wdata0,
    input  logic [3:0]        be0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [31:0]       wdata1,
    input  logic [3:0]        be1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [31:0]       rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [31:0]       WD,
    input  logic [31:0]       RD
);

    arbState_t         state;
    arbState_t         nextState;
    portIdx_t          ptr;
    portIdx_t          winner;
    portIdx_t          latPort;
    logic              anyReq;
    logic              grant;
    logic              finish;
    logic              loadCapture;

    // Request fields latched at grant time; the byte offset is dropped because
    // the memory is word addressed.
    logic              latWe;
    logic [ADDR_W-3:0] latWordAddr;
    logic [31:0]       latWdata;
    logic [ADDR_W-1:0] latAddrAligned;

    // Request fields that are intentionally not used by the datapath.
    logic              unusedInputs;

`ifdef DM_ARB_SUBWORD_EN
    logic [3:0]        latBe;
    logic [31:0]       mergedWord;
    logic [31:0]       mergedReg;
    logic              mergeCapture;

    assign unusedInputs = ^{addr0[1:0], addr1[1:0]};

    dm_byte_merge uMerge (
        .oldWord    (RD),
        .newWord    (latWdata),
        .be         (latBe),
        .mergedWord (mergedWord)
    );
`else
    assign unusedInputs = ^{addr0[1:0], addr1[1:0], be0, be1};
`endif

    assign anyReq         = req0 | req1;
    assign latAddrAligned = {latWordAddr, 2'b00};

    // Round-robin winner: a lone requester wins, a contested grant goes to the pointer.
    always_comb begin
        if (req0 && req1) begin
            winner = ptr;
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end

    // Next-state and memory strobe decode; Reset overrides every strobe and grant.
    always_comb begin
        nextState   = state;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemAddr     = '0;
        WD          = '0;
        grant       = 1'b0;
        finish      = 1'b0;
        loadCapture = 1'b0;
`ifdef DM_ARB_SUBWORD_EN
        mergeCapture = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (anyReq) begin
                    grant     = 1'b1;
                    gnt0      = (winner == PORT0);
                    gnt1      = (winner == PORT1);
                    nextState = ACCESS;
                end
            end
            ACCESS: begin
                MemAddr   = latAddrAligned;
                finish    = 1'b1;
                nextState = IDLE;
                if (!latWe) begin
                    MemRead     = 1'b1;
                    loadCapture = 1'b1;
`ifdef DM_ARB_SUBWORD_EN
                end else if (latBe == FULL_BE) begin
                    MemWrite = 1'b1;
                    WD       = latWdata;
                end else if (latBe != 4'b0000) begin
                    // Partial store: read the old word now, write the merge next cycle.
                    MemRead      = 1'b1;
                    mergeCapture = 1'b1;
                    finish       = 1'b0;
                    nextState    = WRBACK;
                end
`else
                end else begin
                    MemWrite = 1'b1;
                    WD       = latWdata;
                end
`endif
            end
`ifdef DM_ARB_SUBWORD_EN
            WRBACK: begin
                MemAddr   = latAddrAligned;
                MemWrite  = 1'b1;
                WD        = mergedReg;
                finish    = 1'b1;
                nextState = IDLE;
            end
`endif
            default: begin
                nextState = IDLE;
            end
        endcase

        if (Reset) begin
            gnt0        = 1'b0;
            gnt1        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemAddr     = '0;
            WD          = '0;
            grant       = 1'b0;
            finish      = 1'b0;
            loadCapture = 1'b0;
`ifdef DM_ARB_SUBWORD_EN
            mergeCapture = 1'b0;
`endif
        end
    end

    // State, pointer, latched request, completion pulses and load data register.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (Reset) begin
            state       <= IDLE;
            ptr         <= PORT0;
            latPort     <= PORT0;
            latWe       <= 1'b0;
            latWordAddr <= '0;
            latWdata    <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            rdata       <= '0;
        end else begin
            state <= nextState;
            done0 <= finish && (latPort == PORT0);
            done1 <= finish && (latPort == PORT1);
            if (grant) begin
                ptr         <= otherPort(winner);
                latPort     <= winner;
                latWe       <= (winner == PORT1) ? we1 : we0;
                latWordAddr <= (winner == PORT1) ? addr1[ADDR_W-1:2] : addr0[ADDR_W-1:2];
                latWdata    <= (winner == PORT1) ? wdata1 : wdata0;
            end
            if (loadCapture) begin
                rdata <= RD;
            end
        end
    end

`ifdef DM_ARB_SUBWORD_EN
    // Byte enables of the granted request and the merged word for the write-back cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            latBe     <= 4'b0000;
            mergedReg <= '0;
        end else begin
            if (grant) begin
                latBe <= (winner == PORT1) ? be1 : be0;
            end
            if (mergeCapture) begin
                mergedReg <= mergedWord;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural word memory.
// Expectations follow the DM_ARB_SUBWORD_EN setting of the build.
module tb_dm_arbiter;

    logic        Clk;
    logic        Reset;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic [3:0]  be0, be1;
    logic        gnt0, gnt1, done0, done1;
    logic [31:0] rdata;
    logic        MemRead, MemWrite;
    logic [31:0] MemAddr, WD, RD;

    logic [31:0] mem [0:63];
    logic        preWe;
    logic [5:0]  preIdx;
    logic [31:0] preData;

    int testsRun;
    int testsFailed;

    dm_arbiter #(.ADDR_W(32)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .be0(be0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .be1(be1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddr(MemAddr), .WD(WD), .RD(RD)
    );

    always #5 Clk = ~Clk;

    // Word memory: combinational read, write on posedge; preload port for setup.
    assign RD = mem[MemAddr[7:2]];
    always @(posedge Clk) begin
        if (preWe) mem[preIdx] <= preData;
        else if (MemWrite) mem[MemAddr[7:2]] <= WD;
    end

    task automatic preload(input int idx, input logic [31:0] data);
        @(negedge Clk);
        preWe = 1'b1; preIdx = idx[5:0]; preData = data;
        @(negedge Clk);
        preWe = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b1; req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10;
        @(negedge Clk); @(negedge Clk);
        testsRun++; if ({gnt0, gnt1} !== 2'b00) begin testsFailed++; $display("FAIL reset_gnt: got %b expected 00", {gnt0, gnt1}); end
        testsRun++; if ({done0, done1} !== 2'b00) begin testsFailed++; $display("FAIL reset_done: got %b expected 00", {done0, done1}); end
        testsRun++; if (rdata !== 32'h0) begin testsFailed++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        testsRun++; if ({MemRead, MemWrite} !== 2'b00) begin testsFailed++; $display("FAIL reset_strobes: got %b expected 00", {MemRead, MemWrite}); end
        testsRun++; if ({MemAddr, WD} !== 64'h0) begin testsFailed++; $display("FAIL reset_addr_wd: got %h/%h expected 0/0", MemAddr, WD); end
        req0 = 1'b0; Reset = 1'b0;
        @(negedge Clk);
        testsRun++; if ({gnt0, gnt1, MemRead, MemWrite} !== 4'b0000) begin testsFailed++; $display("FAIL idle_quiet: got %b expected 0000", {gnt0, gnt1, MemRead, MemWrite}); end
    endtask

    task automatic test_single_load;
        preload(4, 32'hDEADBEEF);
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h10; #1;
        testsRun++; if ({gnt0, gnt1} !== 2'b10) begin testsFailed++; $display("FAIL load_gnt: got %b expected 10", {gnt0, gnt1}); end
        @(negedge Clk); req0 = 1'b0;
        testsRun++; if ({MemRead, MemWrite, done0} !== 3'b100) begin testsFailed++; $display("FAIL load_read_cycle: got %b expected 100", {MemRead, MemWrite, done0}); end
        testsRun++; if (MemAddr !== 32'h10) begin testsFailed++; $display("FAIL load_addr: got %h expected 10", MemAddr); end
        @(negedge Clk);
        testsRun++; if ({done0, done1, MemRead} !== 3'b100) begin testsFailed++; $display("FAIL load_done: got %b expected 100", {done0, done1, MemRead}); end
        testsRun++; if (rdata !== 32'hDEADBEEF) begin testsFailed++; $display("FAIL load_rdata: got %h expected deadbeef", rdata); end
        @(negedge Clk);
        testsRun++; if (done0 !== 1'b0) begin testsFailed++; $display("FAIL load_done_pulse: got %b expected 0", done0); end
        testsRun++; if (rdata !== 32'hDEADBEEF) begin testsFailed++; $display("FAIL load_rdata_hold: got %h expected deadbeef", rdata); end
    endtask

    task automatic test_round_robin;
        @(negedge Clk);
        Reset = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h0; wdata0 = 32'h0BAD_F00D; be0 = 4'b1111;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h4; wdata1 = 32'h1357_9BDF; be1 = 4'b1111;
        @(negedge Clk); Reset = 1'b0; #1;
        testsRun++; if ({gnt0, gnt1} !== 2'b10) begin testsFailed++; $display("FAIL rr_first_gnt: got %b expected 10", {gnt0, gnt1}); end
        @(negedge Clk); req0 = 1'b0;
        testsRun++; if ({MemWrite, gnt1} !== 2'b10) begin testsFailed++; $display("FAIL rr_write0_busy: got %b expected 10", {MemWrite, gnt1}); end
        testsRun++; if ({MemAddr, WD} !== {32'h0, 32'h0BADF00D}) begin testsFailed++; $display("FAIL rr_write0_data: got %h/%h expected 0/0badf00d", MemAddr, WD); end
        @(negedge Clk);
        testsRun++; if ({done0, gnt1} !== 2'b11) begin testsFailed++; $display("FAIL rr_done0_gnt1: got %b expected 11", {done0, gnt1}); end
        testsRun++; if (mem[0] !== 32'h0BADF00D) begin testsFailed++; $display("FAIL rr_mem0: got %h expected 0badf00d", mem[0]); end
        @(negedge Clk); req1 = 1'b0;
        testsRun++; if ({MemWrite, MemAddr} !== {1'b1, 32'h4}) begin testsFailed++; $display("FAIL rr_write1: got %b/%h expected 1/4", MemWrite, MemAddr); end
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h4; #1;
        testsRun++; if ({done1, gnt0, gnt1} !== 3'b110) begin testsFailed++; $display("FAIL rr_contested_to_port0: got %b expected 110", {done1, gnt0, gnt1}); end
        testsRun++; if (mem[1] !== 32'h13579BDF) begin testsFailed++; $display("FAIL rr_mem1: got %h expected 13579bdf", mem[1]); end
        @(negedge Clk); req0 = 1'b0; req1 = 1'b0;
        @(negedge Clk);
        testsRun++; if ({done0, rdata} !== {1'b1, 32'h0BADF00D}) begin testsFailed++; $display("FAIL rr_load_back: got %b/%h expected 1/0badf00d", done0, rdata); end
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            testsRun++; if ({gnt1, done1, MemRead} !== 3'b000) begin testsFailed++; $display("FAIL rr_dropped_req: got %b expected 000", {gnt1, done1, MemRead}); end
        end
    endtask

    task automatic test_partial_store;
        preload(2, 32'h11223344);
        @(negedge Clk);
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h0000AA00; be1 = 4'b0010; #1;
        testsRun++; if ({gnt0, gnt1} !== 2'b01) begin testsFailed++; $display("FAIL ps_gnt: got %b expected 01", {gnt0, gnt1}); end
        @(negedge Clk); req1 = 1'b0;
`ifdef DM_ARB_SUBWORD_EN
        testsRun++; if ({MemRead, MemWrite, MemAddr} !== {2'b10, 32'h8}) begin testsFailed++; $display("FAIL ps_read_cycle: got %b/%h expected 10/8", {MemRead, MemWrite}, MemAddr); end
        @(negedge Clk);
        testsRun++; if ({MemRead, MemWrite, done1} !== 3'b010) begin testsFailed++; $display("FAIL ps_write_cycle: got %b expected 010", {MemRead, MemWrite, done1}); end
        testsRun++; if ({MemAddr, WD} !== {32'h8, 32'h1122AA44}) begin testsFailed++; $display("FAIL ps_merge: got %h/%h expected 8/1122aa44", MemAddr, WD); end
        @(negedge Clk);
        testsRun++; if (done1 !== 1'b1) begin testsFailed++; $display("FAIL ps_done: got %b expected 1", done1); end
        testsRun++; if (mem[2] !== 32'h1122AA44) begin testsFailed++; $display("FAIL ps_mem: got %h expected 1122aa44", mem[2]); end
`else
        testsRun++; if ({MemRead, MemWrite, WD} !== {2'b01, 32'h0000AA00}) begin testsFailed++; $display("FAIL ps_full_write: got %b/%h expected 01/0000aa00", {MemRead, MemWrite}, WD); end
        @(negedge Clk);
        testsRun++; if ({done1, MemWrite} !== 2'b10) begin testsFailed++; $display("FAIL ps_done: got %b expected 10", {done1, MemWrite}); end
        testsRun++; if (mem[2] !== 32'h0000AA00) begin testsFailed++; $display("FAIL ps_mem: got %h expected 0000aa00", mem[2]); end
`endif
        testsRun++; if (rdata !== 32'h0BADF00D) begin testsFailed++; $display("FAIL ps_rdata_kept: got %h expected 0badf00d", rdata); end
        @(negedge Clk);
    endtask

    task automatic test_empty_be;
        preload(3, 32'hCAFEF00D);
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'hC; wdata0 = 32'h12345678; be0 = 4'b0000; #1;
        testsRun++; if (gnt0 !== 1'b1) begin testsFailed++; $display("FAIL eb_gnt: got %b expected 1", gnt0); end
        @(negedge Clk); req0 = 1'b0;
`ifdef DM_ARB_SUBWORD_EN
        testsRun++; if ({MemRead, MemWrite, done0} !== 3'b000) begin testsFailed++; $display("FAIL eb_no_strobe: got %b expected 000", {MemRead, MemWrite, done0}); end
        @(negedge Clk);
        testsRun++; if ({done0, MemWrite} !== 2'b10) begin testsFailed++; $display("FAIL eb_done: got %b expected 10", {done0, MemWrite}); end
        testsRun++; if (mem[3] !== 32'hCAFEF00D) begin testsFailed++; $display("FAIL eb_mem: got %h expected cafef00d", mem[3]); end
`else
        testsRun++; if ({MemRead, MemWrite, WD} !== {2'b01, 32'h12345678}) begin testsFailed++; $display("FAIL eb_full_write: got %b/%h expected 01/12345678", {MemRead, MemWrite}, WD); end
        @(negedge Clk);
        testsRun++; if ({done0, MemWrite} !== 2'b10) begin testsFailed++; $display("FAIL eb_done: got %b expected 10", {done0, MemWrite}); end
        testsRun++; if (mem[3] !== 32'h12345678) begin testsFailed++; $display("FAIL eb_mem: got %h expected 12345678", mem[3]); end
`endif
        @(negedge Clk);
        testsRun++; if ({done0, MemWrite} !== 2'b00) begin testsFailed++; $display("FAIL eb_after: got %b expected 00", {done0, MemWrite}); end
    endtask

    task automatic test_reset_mid;
        preload(5, 32'hA5A5A5A5);
        @(negedge Clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h14; wdata0 = 32'h000000FF; be0 = 4'b0001; #1;
        testsRun++; if (gnt0 !== 1'b1) begin testsFailed++; $display("FAIL rm_gnt: got %b expected 1", gnt0); end
        @(negedge Clk); req0 = 1'b0;
`ifdef DM_ARB_SUBWORD_EN
        testsRun++; if (MemRead !== 1'b1) begin testsFailed++; $display("FAIL rm_read: got %b expected 1", MemRead); end
        @(negedge Clk);
        testsRun++; if ({MemWrite, WD} !== {1'b1, 32'hA5A5A5FF}) begin testsFailed++; $display("FAIL rm_wrback: got %b/%h expected 1/a5a5a5ff", MemWrite, WD); end
`else
        testsRun++; if ({MemWrite, WD} !== {1'b1, 32'h000000FF}) begin testsFailed++; $display("FAIL rm_write: got %b/%h expected 1/000000ff", MemWrite, WD); end
`endif
        Reset = 1'b1; #1;
        testsRun++; if ({MemWrite, MemRead, MemAddr} !== {2'b00, 32'h0}) begin testsFailed++; $display("FAIL rm_forced_low: got %b/%h expected 00/0", {MemWrite, MemRead}, MemAddr); end
        @(negedge Clk); Reset = 1'b0;
        testsRun++; if ({done0, done1} !== 2'b00) begin testsFailed++; $display("FAIL rm_no_done: got %b expected 00", {done0, done1}); end
        testsRun++; if (mem[5] !== 32'hA5A5A5A5) begin testsFailed++; $display("FAIL rm_mem: got %h expected a5a5a5a5", mem[5]); end
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h17; #1;
        testsRun++; if (gnt1 !== 1'b1) begin testsFailed++; $display("FAIL rm_idle_after: got %b expected 1", gnt1); end
        @(negedge Clk); req1 = 1'b0;
        testsRun++; if ({done0, MemRead, MemAddr} !== {2'b01, 32'h14}) begin testsFailed++; $display("FAIL rm_reload: got %b/%h expected 01/14", {done0, MemRead}, MemAddr); end
        @(negedge Clk);
        testsRun++; if ({done0, done1, rdata} !== {2'b01, 32'hA5A5A5A5}) begin testsFailed++; $display("FAIL rm_reload_done: got %b/%h expected 01/a5a5a5a5", {done0, done1}, rdata); end
    endtask

    initial begin
        testsRun = 0; testsFailed = 0;
        Clk = 1'b0; Reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
        preWe = 1'b0; preIdx = '0; preData = '0;
        test_reset();
        test_single_load();
        test_round_robin();
        test_partial_store();
        test_empty_be();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
